pda_bracket_matcher: RTL
========================

# pda_bracket_matcher

Parametrised pushdown-automaton matcher, successor to the fixed three-term `pda` block. It consumes a character stream, one character per cycle, and checks that NUM_PAIRS kinds of open/close delimiters are balanced and properly nested, using a LIFO stack of depth DEPTH. At each terminator it emits a one-cycle verdict with an error cause. It sits in the same character-stream datapath as `pda`, between the input character source and the match-reporting logic.

## Interface
- `CHAR_W`, default 8: character width in bits.
- `NUM_PAIRS`, default 3: number of delimiter pairs (channels).
- `DEPTH`, default 16: stack depth in entries, minimum 2.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low. Low clears all state immediately.
- `in_valid` in 1: `in_char` is presented this cycle.
- `in_char` in CHAR_W: stream character. All-zeros is the string terminator.
- `open_terms` in NUM_PAIRS*CHAR_W: open delimiter of pair i at bits [i*CHAR_W +: CHAR_W]. Must be static while a string is in progress.
- `close_terms` in NUM_PAIRS*CHAR_W: close delimiter of pair i, same packing and same static rule.
- `done` out 1: one-cycle pulse; the verdict is valid.
- `matched` out 1: string balanced. Valid with `done`, held until the next `done`.
- `err_code` out 2: failure cause, same validity as `matched`. Values: 0 none, 1 mismatch, 2 underflow/overflow, 3 unclosed.
- `depth` out $clog2(DEPTH+1): current stack occupancy.

## Operation
- Each stack entry holds a pair index of $clog2(NUM_PAIRS) bits (minimum 1 bit).
- The FSM has two states:
  - SCAN: chars are being classified.
  - DRAIN: an error has been latched; chars are discarded until the terminator.
- Classification in SCAN, for each `in_valid` char, in priority order:
  1. Terminator:
     - Verdict is `matched` = (depth==0).
     - `err_code` = 3 if depth!=0, else 0.
     - The stack is cleared and the FSM stays in SCAN.
  2. Close of pair i:
     - Stack non-empty and top==i: pop.
     - Stack empty: underflow, `err_code` latched as 2, go to DRAIN.
     - Top!=i:
       - If the char is also the open of some pair, handle it as rule 3.
       - Otherwise mismatch, `err_code` latched as 1, go to DRAIN.
  3. Open of pair i:
     - Push i.
     - If depth==DEPTH: overflow, `err_code` latched as 2, go to DRAIN.
  4. Any other char: ignored.
- A character equal in both roles (e.g. a quote pair) closes when top matches and opens otherwise.
- When several pairs match a character, the lowest pair index wins.
- DRAIN: chars are ignored until the terminator. At the terminator: `matched`=0, the latched `err_code` is reported, the stack is cleared, and the FSM returns to SCAN.
- Only the first error of a string is reported.
- Cycles with `in_valid`=0 change nothing.

## Timing
- Throughput is one char per cycle, with no backpressure. The block always accepts input.
- `depth` updates on the edge that samples the char and is visible the next cycle.
- Verdict latency: `done`, `matched` and `err_code` register on the edge that samples the terminator, so they are visible one cycle after the terminator is presented.
- Back-to-back strings are legal: the char following a terminator belongs to the new string and is processed normally in the same cycle `done` is high.
- Reset values:
  - `done`=0, `matched`=0, `err_code`=0, `depth`=0.
  - FSM in SCAN, stack pointer 0.
- Reset asserted mid-string discards the string. No `done` is produced for it.
- A terminator with an empty stream gives `matched`=1, `err_code`=0.

## Structure
- Package `pda_pkg` holds:
  - the state enum `pda_state_t` {SCAN, DRAIN};
  - the `err_code` constants ERR_NONE, ERR_MISMATCH, ERR_BOUND, ERR_UNCLOSED;
  - the terminator constant.
- Sub-module `pda_stack` is a parametrised LIFO with:
  - push and pop ports;
  - `top`, `empty`, `full` and `count` outputs;
  - a synchronous `clear` input.
- The top level holds the combinational per-pair comparators, the priority encoder and the FSM.

## Test plan
- Use default parameters with pairs "()", "[]", "{}" unless stated.
- Balanced: "a([b]{c})" then 0 -> `depth` peaks at 2; one cycle after the terminator `done`=1, `matched`=1, `err_code`=0, `depth`=0.
- Mismatch: "([)]" then 0 -> DRAIN entered at ')'; verdict `matched`=0, `err_code`=1; the trailing "]" is ignored.
- Underflow: ")" then 0 -> `matched`=0, `err_code`=2.
- Overflow: with DEPTH=4, "(((((" then 0 -> `matched`=0, `err_code`=2.
- Unclosed: "((" then 0 -> `matched`=0, `err_code`=3.
- Quote pair: with pair 0 set to '"' '"', the string `"("")"` then 0 -> `matched`=1.
- Streaming and reset:
  - Back-to-back "()" 0 "(" 0 with no idle cycle gives two `done` pulses: first `matched`=1, then `matched`=0 with `err_code`=3.
  - Reset pulsed low after "((" clears `depth` to 0 at once; a following "()" 0 gives `matched`=1.

Source files
------------

// File: rtl/pda_pkg.sv
// Shared types and constants for the pushdown bracket matcher.
package pda_pkg;

  typedef enum logic {
    SCAN  = 1'b0,
    DRAIN = 1'b1
  } pda_state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_BOUND    = 2'd2;
  localparam logic [1:0] ERR_UNCLOSED = 2'd3;

  // String terminator value, widened to CHAR_W at the point of use.
  localparam int unsigned TERM_VALUE = 0;

endpackage

// File: rtl/pda_stack.sv
// Parametrised LIFO of pair indices with a synchronous clear.
module pda_stack #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    last;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign last  = count - CW'(1);
  assign top   = empty ? '0 : mem[last[AW-1:0]];

  // Occupancy: clear beats push, push beats pop; pushes when full and pops when empty are dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end
  end

  // Entry storage: write the slot just above the current top.
  always_ff @(posedge clock) begin
    if (!clear && push && !full) begin
      mem[count[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/pda_bracket_matcher.sv
// Checks nesting/balance of NUM_PAIRS delimiter kinds over a character stream.
module pda_bracket_matcher
  import pda_pkg::*;
#(
  parameter int unsigned CHAR_W    = 8,
  parameter int unsigned NUM_PAIRS = 3,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [CHAR_W-1:0]             in_char,
  input  logic [NUM_PAIRS*CHAR_W-1:0]   open_terms,
  input  logic [NUM_PAIRS*CHAR_W-1:0]   close_terms,
  output logic                          done,
  output logic                          matched,
  output logic [1:0]                    err_code,
  output logic [$clog2(DEPTH+1)-1:0]    depth
);

  localparam int unsigned PW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;

  pda_state_t state, state_next;

  logic          open_hit, close_hit, is_term;
  logic [PW-1:0] open_idx, close_idx;
  logic [PW-1:0] stk_top;
  logic          stk_empty, stk_full;
  logic          stk_push, stk_pop, stk_clear;
  logic [1:0]    err_hold, err_hold_next;
  logic          done_next, matched_next;
  logic [1:0]    err_next;

  pda_stack #(
    .WIDTH (PW),
    .DEPTH (DEPTH)
  ) u_stack (
    .clock     (clock),
    .reset     (reset),
    .clear     (stk_clear),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (open_idx),
    .top       (stk_top),
    .empty     (stk_empty),
    .full      (stk_full),
    .count     (depth)
  );

  // Per-pair comparators with lowest-index-wins priority encoding.
  always_comb begin
    is_term   = (in_char == CHAR_W'(TERM_VALUE));
    open_hit  = 1'b0;
    open_idx  = '0;
    close_hit = 1'b0;
    close_idx = '0;
    for (int unsigned i = 0; i < NUM_PAIRS; i++) begin
      if (!open_hit && open_terms[i*CHAR_W +: CHAR_W] == in_char) begin
        open_hit = 1'b1;
        open_idx = PW'(i);
      end
      if (!close_hit && close_terms[i*CHAR_W +: CHAR_W] == in_char) begin
        close_hit = 1'b1;
        close_idx = PW'(i);
      end
    end
  end

  // Next-state, stack control and verdict logic.
  always_comb begin
    state_next    = state;
    stk_push      = 1'b0;
    stk_pop       = 1'b0;
    stk_clear     = 1'b0;
    done_next     = 1'b0;
    matched_next  = matched;
    err_next      = err_code;
    err_hold_next = err_hold;
    if (in_valid) begin
      unique case (state)
        SCAN: begin
          if (is_term) begin
            done_next    = 1'b1;
            matched_next = stk_empty;
            err_next     = stk_empty ? ERR_NONE : ERR_UNCLOSED;
            stk_clear    = 1'b1;
          end else if (close_hit && !stk_empty && stk_top == close_idx) begin
            stk_pop = 1'b1;
          // A char that is also an opener falls through to the push branch
          // rather than erroring, so symmetric delimiters open on a non-matching top.
          end else if (close_hit && !open_hit) begin
            err_hold_next = stk_empty ? ERR_BOUND : ERR_MISMATCH;
            state_next    = DRAIN;
          end else if (open_hit) begin
            if (stk_full) begin
              err_hold_next = ERR_BOUND;
              state_next    = DRAIN;
            end else begin
              stk_push = 1'b1;
            end
          end
        end
        DRAIN: begin
          if (is_term) begin
            done_next    = 1'b1;
            matched_next = 1'b0;
            err_next     = err_hold;
            stk_clear    = 1'b1;
            state_next   = SCAN;
          end
        end
        default: state_next = SCAN;
      endcase
    end
  end

  // State, latched error cause and registered verdict.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= SCAN;
      err_hold <= ERR_NONE;
      done     <= 1'b0;
      matched  <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      state    <= state_next;
      err_hold <= err_hold_next;
      done     <= done_next;
      matched  <= matched_next;
      err_code <= err_next;
    end
  end

endmodule
